// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared constants and types for the signed frame accumulator
package accum_pkg;

  // Default parameter values for signed_accum and sat_add
  localparam int DEF_WIDTH = 8;
  localparam int DEF_COUNT = 4;
  localparam int DEF_SAT   = 1;

  // Two-state frame FSM: collecting samples, or presenting a finished frame
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Sample counter width; a single-sample frame still needs one bit of storage
  function automatic int cnt_width(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - two's-complement add with overflow detect and optional clamp
module sat_add
  import accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SAT   = DEF_SAT
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] raw_sum;

  // Add, flag a sign flip between like-signed operands, clamp toward the operand sign
  always_comb begin
    raw_sum = acc_i + data_i;
    ovf_o   = (acc_i[WIDTH-1] == data_i[WIDTH-1]) &&
              (raw_sum[WIDTH-1] != acc_i[WIDTH-1]);
    sum_o   = raw_sum;
    if ((SAT != 0) && ovf_o) begin
      sum_o = acc_i[WIDTH-1] ? NEG_MIN : POS_MAX;
    end
  end

endmodule

// File: rtl/signed_accum.sv
// rtl/signed_accum.sv - frame accumulator of COUNT signed samples with valid/ready handshakes
module signed_accum
  import accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT,
  parameter int SAT   = DEF_SAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             sticky_ovf
);

  localparam int            CW       = cnt_width(COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             frame_ovf_q;
  logic             sticky_q;

  logic [WIDTH-1:0] acc_d;
  logic             add_ovf;

  sat_add #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_sat_add (
    .acc_i  (acc_q),
    .data_i (in_data),
    .sum_o  (acc_d),
    .ovf_o  (add_ovf)
  );

  // Frame FSM with its datapath: clear beats everything, HOLD waits for the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      frame_ovf_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      frame_ovf_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q       <= acc_d;
            frame_ovf_q <= frame_ovf_q | add_ovf;
            sticky_q    <= sticky_q | add_ovf;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          // Result is consumed; next frame starts from zero on the following cycle
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_ovf_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  // Handshake and result outputs decode directly from registered state
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_data   = out_valid ? acc_q : '0;
  assign out_ovf    = out_valid & frame_ovf_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: doc/signed_accum.md
SIGNED_ACCUM -- requirements
Module: signed_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the two's-complement operand and result width in bits.
REQ-002 The block SHALL have parameter COUNT, default 4, giving the samples per frame; legal range is 1 or more.
REQ-003 The block SHALL have parameter SAT, default 1; 1 selects saturate mode and 0 selects wrap mode.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous frame abort and flag clear.
REQ-007 in_valid  input  1  in_data is presented.
REQ-008 in_data  input  WIDTH  signed sample.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_valid  output  1  frame result is presented.
REQ-011 out_data  output  WIDTH  signed frame sum.
REQ-012 out_ovf  output  1  at least one overflow occurred in this frame.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 sticky_ovf  output  1  an overflow has occurred since the last reset or clear.

Function
REQ-015 The FSM SHALL have two states, ACCUM and HOLD; in_ready SHALL equal (state==ACCUM) and out_valid SHALL equal (state==HOLD).
REQ-016 A sample SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 On acceptance, the raw sum SHALL be acc plus in_data, truncated to WIDTH bits.
REQ-018 Overflow SHALL be flagged when acc and in_data have equal sign bits and the raw sum has a different sign bit.
REQ-019 In SAT=1 mode, on overflow, acc SHALL load 2^(WIDTH-1)-1 for a positive overflow or -2^(WIDTH-1) for a negative overflow; otherwise acc SHALL load the raw sum.
REQ-020 In SAT=0 mode, acc SHALL always load the raw sum.
REQ-021 On each acceptance, frame_ovf SHALL be ORed with the overflow flag, and sticky_ovf SHALL be ORed with the overflow flag.
REQ-022 A sample counter SHALL run 0..COUNT-1; the acceptance made at COUNT-1 SHALL move the FSM to HOLD, with out_valid high on the next cycle (1-cycle latency).
REQ-023 In HOLD, out_data SHALL equal the final acc and out_ovf SHALL equal frame_ovf, with this final sample's overflow included.
REQ-024 out_data and out_ovf SHALL stay stable while out_valid is high and out_ready is low.
REQ-025 In HOLD with out_ready=1, the FSM SHALL return to ACCUM and zero acc, the counter and frame_ovf; back-to-back frames then have 1 dead input cycle.
REQ-026 When out_valid is 0, out_data SHALL be 0 and out_ovf SHALL be 0.
REQ-027 clear=1 SHALL take priority over every other event and go to ACCUM with acc, counter, frame_ovf and sticky_ovf all zeroed; a sample offered in the same cycle SHALL be dropped.
REQ-028 With COUNT=1, every accepted sample SHALL form its own frame, computed as 0 plus the sample.
REQ-029 in_valid arriving during HOLD SHALL be ignored, with no acceptance.

Reset
REQ-030 rst_n=0 SHALL immediately force state=ACCUM, acc=0, counter=0, frame_ovf=0 and sticky_ovf=0, giving in_ready=1, out_valid=0, out_data=0, out_ovf=0 and sticky_ovf=0.
REQ-031 A reset asserted during HOLD SHALL discard the pending result without waiting for out_ready.

Structure
REQ-032 The shared package accum_pkg SHALL hold the state encoding constants (ACCUM=0, HOLD=1) and the default parameter values.
REQ-033 The combinational sub-module sat_add SHALL contain the add, overflow detection and clamp, parametrised by WIDTH and SAT; signed_accum SHALL contain the FSM, counter and registers.
REQ-034 The counter width SHALL be max(1, clog2(COUNT)).

Verification (WIDTH=8, COUNT=4 unless stated)
REQ-035 SAT=1, samples 7F,01,00,00 -> out_data=7F, out_ovf=1, sticky_ovf=1.
REQ-036 SAT=0, samples 7F,01,00,00 -> out_data=80, out_ovf=1; samples 80,80,00,00 -> out_data=00, out_ovf=1.
REQ-037 SAT=1, samples 7F,7F,81,00 -> the sum clamps at 7F then reaches 00; out_data=00, out_ovf=1; next frame 01,02,03,04 -> 0A, out_ovf=0, sticky_ovf still 1.
REQ-038 Samples 01,02,03,04 with out_ready low for 3 cycles -> out_valid and 0A held steady, in_ready=0, an in_valid pulse during HOLD is ignored; release -> in_ready=1 on the next cycle.
REQ-039 clear after 2 samples, then 05,05,05,05 -> out_data=14, sticky_ovf=0; clear together with in_valid -> sample dropped.
REQ-040 rst_n pulsed low mid-HOLD -> all outputs drop to reset values without a clock edge; COUNT=1 with sample 85 -> out_data=85 after 1 cycle.
